// File: rtl/snn_pkg.sv
// Shared spiking-network definitions: default layer geometry, the spike-time word
// format and the encoder state type.
package snn_pkg;

  localparam int DEF_TIME_PERIOD = 8;
  localparam int DEF_NUM_SPIKES  = 16;
  localparam int DEF_PIX_BITS    = 8;
  localparam int DEF_THRESH      = 16;
  localparam int DEF_TW          = $clog2(DEF_TIME_PERIOD);

  // MSB set means "no spike"; the low DEF_TW bits carry the spike time.
  typedef logic [DEF_TW:0] spike_time_t;

  typedef enum logic {
    ENC_IDLE = 1'b0,
    ENC_RUN  = 1'b1
  } enc_state_t;

endpackage

// File: rtl/intensity_to_spike_time.sv
// Combinational time-to-first-spike encoder: brighter pixels spike earlier and
// pixels below threshold never spike.
module intensity_to_spike_time #(
  parameter int TIME_PERIOD = 8,
  parameter int PIX_BITS    = 8,
  parameter int THRESH      = 16,
  localparam int TW         = $clog2(TIME_PERIOD)
) (
  input  logic [PIX_BITS-1:0] pix,
  output logic [TW:0]         spike_time
);

  localparam logic [PIX_BITS:0]   THR    = (PIX_BITS+1)'(THRESH);
  localparam logic [PIX_BITS-1:0] LAST_T = PIX_BITS'(TIME_PERIOD - 1);

  logic [PIX_BITS-1:0] inv;
  logic [PIX_BITS-1:0] scaled;

  always_comb begin
    inv    = ~pix;
    // Keep the top TW bits of the inverted intensity, clamped to the window length.
    scaled = inv >> (PIX_BITS - TW);
    if ({1'b0, pix} < THR) begin
      spike_time = {1'b1, {TW{1'b0}}};
    end else if (scaled > LAST_T) begin
      spike_time = {1'b0, LAST_T[TW-1:0]};
    end else begin
      spike_time = {1'b0, scaled[TW-1:0]};
    end
  end

endmodule

// File: rtl/spike_encoder.sv
// Collects NUM_SPIKES encoded pixels into a shadow buffer and replays them as a
// fixed spike-time frame over a TIME_PERIOD-cycle window, back to back when possible.
module spike_encoder
  import snn_pkg::*;
#(
  parameter int TIME_PERIOD = DEF_TIME_PERIOD,
  parameter int NUM_SPIKES  = DEF_NUM_SPIKES,
  parameter int PIX_BITS    = DEF_PIX_BITS,
  parameter int THRESH      = DEF_THRESH,
  localparam int TW         = $clog2(TIME_PERIOD),
  localparam int ST_W       = TW + 1,
  localparam int CW         = $clog2(NUM_SPIKES + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pix_valid,
  output logic                       pix_ready,
  input  logic [PIX_BITS-1:0]        pix_data,
  output logic [NUM_SPIKES*ST_W-1:0] spike_times,
  output logic [TW:0]                time_val,
  output logic                       frame_valid,
  output logic                       frame_start,
  output logic                       frame_done,
  output enc_state_t                 state_dbg
);

  localparam logic [ST_W-1:0] NO_SPIKE = {1'b1, {TW{1'b0}}};
  localparam logic [TW:0]     LAST_T   = (TW+1)'(TIME_PERIOD - 1);
  localparam logic [CW-1:0]   FULL     = CW'(NUM_SPIKES);

  enc_state_t      state;
  logic [CW-1:0]   fill_count;
  logic [ST_W-1:0] shadow [NUM_SPIKES];
  logic [ST_W-1:0] enc;
  logic            full;
  logic            accept;
  logic            last_t;
  logic            swap;

  intensity_to_spike_time #(
    .TIME_PERIOD (TIME_PERIOD),
    .PIX_BITS    (PIX_BITS),
    .THRESH      (THRESH)
  ) u_enc (
    .pix        (pix_data),
    .spike_time (enc)
  );

  // Handshake: a pixel transfers on a rising edge where pix_valid && pix_ready;
  // pix_ready never depends on pix_valid, and the source holds pix_data until accepted.
  assign full      = (fill_count == FULL);
  assign pix_ready = !rst && (fill_count < FULL);
  assign accept    = pix_valid && pix_ready;
  assign last_t    = (time_val == LAST_T);
  assign swap      = full && ((state == ENC_IDLE) || last_t);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ENC_IDLE;
      fill_count  <= '0;
      time_val    <= '0;
      frame_valid <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      for (int i = 0; i < NUM_SPIKES; i++) begin
        spike_times[i*ST_W +: ST_W] <= NO_SPIKE;
        shadow[i]                   <= NO_SPIKE;
      end
    end else begin
      frame_start <= 1'b0;
      frame_done  <= 1'b0;

      // accept and swap are mutually exclusive: a full buffer deasserts pix_ready.
      if (accept) begin
        for (int i = 0; i < NUM_SPIKES; i++) begin
          if (fill_count == CW'(i)) shadow[i] <= enc;
        end
        fill_count <= fill_count + 1'b1;
      end

      if (swap) begin
        state       <= ENC_RUN;
        fill_count  <= '0;
        time_val    <= '0;
        frame_valid <= 1'b1;
        frame_start <= 1'b1;
        for (int i = 0; i < NUM_SPIKES; i++) begin
          spike_times[i*ST_W +: ST_W] <= shadow[i];
        end
      end else if (state == ENC_RUN) begin
        if (last_t) begin
          state       <= ENC_IDLE;
          time_val    <= '0;
          frame_valid <= 1'b0;
          for (int i = 0; i < NUM_SPIKES; i++) begin
            spike_times[i*ST_W +: ST_W] <= NO_SPIKE;
          end
        end else begin
          time_val   <= time_val + 1'b1;
          frame_done <= ((time_val + 1'b1) == LAST_T);
        end
      end
    end
  end

endmodule

// File: doc/spike_encoder.md
SPIKE_ENCODER -- requirements
Module: spike_encoder

Interface
REQ-001 Parameter TIME_PERIOD, 8, cycles per inference window; SHALL be at least 2.
REQ-002 Parameter NUM_SPIKES, 16, number of input lines (pixels) per frame.
REQ-003 Parameter PIX_BITS, 8, pixel intensity width; SHALL satisfy PIX_BITS >= TW, where TW = $clog2(TIME_PERIOD).
REQ-004 Parameter THRESH, 16, minimum intensity that produces a spike.
REQ-005 Port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-006 Port rst, input, 1, synchronous, active-high reset.
REQ-007 Port pix_valid, input, 1, pixel offered.
REQ-008 Port pix_ready, output, 1, pixel accepted when pix_valid && pix_ready at a rising edge.
REQ-009 Port pix_data, input, PIX_BITS, pixel intensity.
REQ-010 Port spike_times, output, NUM_SPIKES x (TW+1) packed: bit TW = 1 means no spike; bits TW-1:0 hold the spike time.
REQ-011 Port time_val, output, TW+1, current time step of the active window.
REQ-012 Port frame_valid, output, 1, high while a window is running.
REQ-013 Port frame_start, output, 1, high in the cycle where time_val == 0 and frame_valid is high.
REQ-014 Port frame_done, output, 1, high in the cycle where time_val == TIME_PERIOD-1 and frame_valid is high.

Function
REQ-015 Encoding SHALL be as follows:
- pix < THRESH -> {1'b1, TW'b0}.
- Otherwise -> {1'b0, min((2^PIX_BITS-1-pix) >> (PIX_BITS-TW), TIME_PERIOD-1)}.
REQ-016 Each pixel SHALL be encoded when accepted and stored in a shadow buffer. The first pixel accepted after a swap or reset goes to index 0, and each following pixel goes to the next index.
REQ-017 pix_ready SHALL equal (!rst && fill_count < NUM_SPIKES).
REQ-018 The block SHALL have two states, IDLE and RUN.
REQ-019 IDLE behaviour:
- Outputs: time_val = 0, frame_valid = 0, spike_times all no-spike.
- Transition: when fill_count == NUM_SPIKES, the next edge copies the shadow buffer to spike_times, sets fill_count = 0, time_val = 0, and enters RUN.
REQ-020 RUN behaviour:
- time_val SHALL increment by 1 per cycle.
- spike_times SHALL stay constant for the whole window.
REQ-021 RUN at time_val == TIME_PERIOD-1:
- If fill_count == NUM_SPIKES, the next edge swaps the shadow buffer into spike_times, sets time_val = 0, and stays in RUN, giving back-to-back windows with no gap cycle.
- Otherwise the next edge enters IDLE.
REQ-022 Latency: with IDLE and an empty buffer, if the last pixel is accepted at edge N, then fill_count becomes full at N, and the edge N+1 makes frame_valid = 1, time_val = 0 and frame_start = 1.
REQ-023 A pixel SHALL be accepted during any RUN or IDLE cycle whenever pix_ready is high.
REQ-024 No pixel SHALL be dropped or duplicated under backpressure.
REQ-025 pix_ready SHALL return to 1 in the cycle after a swap.
REQ-026 frame_start and frame_done SHALL be single-cycle pulses.
REQ-027 frame_start and frame_done SHALL both be high in the same cycle only if TIME_PERIOD == 1; that case is excluded by REQ-001.

Reset
REQ-028 While rst is high at an edge, the block SHALL:
- enter IDLE;
- set fill_count = 0, clearing the shadow buffer;
- set spike_times all {1'b1, 0}, time_val = 0, frame_valid = 0, frame_start = 0, frame_done = 0.
REQ-029 Reset asserted mid-window SHALL abandon both the window and any partial shadow frame, with no further pulses.

Structure
REQ-030 TIME_PERIOD, NUM_SPIKES, PIX_BITS, THRESH defaults and a spike_time_t typedef (TW+1 bits) SHALL live in shared package snn_pkg, consistent with the layer's spike-time format.
REQ-031 Per-pixel encoding SHALL be a combinational sub-module, intensity_to_spike_time; the FSM, counters and buffers stay in spike_encoder.
REQ-032 The expected implementation size is about 150-250 RTL lines.

Verification (TIME_PERIOD=8, NUM_SPIKES=4, PIX_BITS=8, THRESH=16, TW=3)
REQ-033 Reset -> spike_times = {4'b1000 x4}, time_val = 0, frame_valid = 0, pix_ready = 0 during rst and 1 after.
REQ-034 Stream {255,128,32,0} then pix_valid = 0:
- spike_times = {0:4'b0000, 1:4'b0011, 2:4'b0110, 3:4'b1000};
- time_val runs 0..7 with frame_start at 0 and frame_done at 7;
- IDLE follows.
REQ-035 Second frame streamed during the first window: pix_ready drops after 4 accepts; time_val goes 7 -> 0 with no gap and the new spike_times appear in the same cycle.
REQ-036 pix_valid held high continuously: exactly 4 accepts per window, each in pixel order, with no loss or repeat over 3 windows.
REQ-037 Threshold boundary: pix 15 -> 4'b1000; pix 16 -> 4'b0111; pix 224 -> 4'b0000.
REQ-038 rst pulsed at time_val == 3 with 2 shadow pixels loaded -> next cycle IDLE with all outputs at reset values; a fresh 4-pixel frame then starts at index 0.
